bch_encode_packer: RTL

BCH_ENCODE_PACKER -- requirements
Module: bch_encode_packer

---
 rtl/bch_encode_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bch_encode_packer.sv
// Packs BITS-wide BCH encoder samples LSB-first into WORD_BITS words and buffers them in a small FIFO.
// Define BCH_PACK_ECC_FLAG_EN to carry a per-word "contains ecc bits" flag on out_ecc.
module bch_encode_packer #(
    parameter int BITS       = 1,
    parameter int WORD_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_ce,
    input  logic [BITS-1:0]      in_data,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic                 in_ecc,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 out_ecc,
    output logic                 frame_err
);
    localparam int SPW = WORD_BITS / BITS;
    localparam int CW  = $clog2(SPW);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(SPW - 1);
    localparam logic [PW:0]   FULL     = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, PACK} state_t;

    typedef struct packed {
        logic [WORD_BITS-1:0] data;
        logic                 last;
        logic                 ecc;
    } entry_t;

    state_t               state, state_nx;
    logic [WORD_BITS-1:0] acc, acc_nx, merged;
    logic [CW-1:0]        cnt, cnt_nx, idx;
    logic                 accept, take, done, push, pop, err_nx, word_ecc;

    entry_t               mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          count;
    entry_t               head;

`ifdef BCH_PACK_ECC_FLAG_EN
    logic ecc_acc, ecc_nx;
`else
    logic ecc_unused;
    assign ecc_unused = in_ecc;
`endif

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head.data : '0;
    assign out_last  = out_valid && head.last;
    assign out_ecc   = out_valid && head.ecc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
`ifdef BCH_PACK_ECC_FLAG_EN
            ecc_acc   <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
            frame_err <= err_nx;
`ifdef BCH_PACK_ECC_FLAG_EN
            ecc_acc   <= ecc_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        push     = 1'b0;
        err_nx   = 1'b0;
        take     = 1'b0;
        accept   = in_ce && in_ready;
        // A first-flagged sample always lands in slot 0 of a fresh word.
        idx      = in_first ? '0 : cnt;
        merged   = in_first ? '0 : acc;
        for (int i = 0; i < SPW; i++)
            if (idx == CW'(i)) merged[i*BITS +: BITS] = in_data;
        done     = in_last || (idx == LAST_IDX);
`ifdef BCH_PACK_ECC_FLAG_EN
        ecc_nx   = ecc_acc;
        word_ecc = (in_first ? 1'b0 : ecc_acc) | in_ecc;
`else
        word_ecc = 1'b0;
`endif
        if (accept) begin
            if (state == PACK) begin
                take   = 1'b1;
                err_nx = in_first && (cnt != '0);
            end else begin
                take   = in_first;
            end
        end
        if (take) begin
            if (done) begin
                push     = 1'b1;
                acc_nx   = '0;
                cnt_nx   = '0;
                state_nx = in_last ? IDLE : PACK;
`ifdef BCH_PACK_ECC_FLAG_EN
                ecc_nx   = 1'b0;
`endif
            end else begin
                acc_nx   = merged;
                cnt_nx   = idx + CW'(1);
                state_nx = PACK;
`ifdef BCH_PACK_ECC_FLAG_EN
                ecc_nx   = word_ecc;
`endif
            end
        end
    end

    // in_ready depends only on count, so push never targets a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: merged, last: in_last, ecc: word_ecc};
    end
endmodule
